// File: rtl/spi_ram_pkg.sv
// Command encodings, FSM states and grant owners shared by the SPI RAM controller.
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_SPI  = 1'b0,
    GNT_HOST = 1'b1
  } gnt_e;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM: read-first, registered output, contents never reset.
module sp_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [7:0]           wdata,
  output logic [7:0]           q
);

  logic [7:0] mem_q [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    q <= mem_q[addr];
  end

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI command decoder and RAM sequencer; round-robin shares the RAM with a host port.
// Each access is IDLE -> ACCESS (-> RDATA for reads); one pending SPI slot, sticky overrun.
module spi_ram_ctrl
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [9:0]           din,
  input  logic                 rx_valid,
  output logic [7:0]           dout,
  output logic                 tx_valid,
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic [7:0]           host_rdata,
  output logic                 host_rvalid,
  output logic                 overrun
);

  state_e               state_q, state_d;
  gnt_e                 gnt_q, gnt_d, last_q, last_d, pick;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic                 spi_pend_q, spi_pend_d;
  logic [1:0]           spi_cmd_q, spi_cmd_d;
  logic [7:0]           spi_byte_q, spi_byte_d;
  logic [7:0]           dout_q, dout_d, host_rdata_q, host_rdata_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 host_gnt_q, host_gnt_d;
  logic                 host_rvalid_q, host_rvalid_d;
  logic                 overrun_q, overrun_d;

  logic                 spi_acc, acc_write, ram_we;
  logic [ADDR_SIZE-1:0] ram_addr;
  logic [7:0]           ram_wdata, ram_q;

  // Pointers are taken from the live registers during ACCESS, not at command capture.
  assign spi_acc   = (state_q == ACCESS) && (gnt_q == GNT_SPI);
  assign acc_write = spi_acc ? (spi_cmd_q == CMD_WR_DATA) : host_we;
  assign ram_we    = (state_q == ACCESS) && acc_write && rst_n;
  assign ram_addr  = spi_acc ? ((spi_cmd_q == CMD_WR_DATA) ? wr_addr_q : rd_addr_q) : host_addr;
  assign ram_wdata = spi_acc ? spi_byte_q : host_wdata;

  sp_ram #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .q    (ram_q)
  );

  // On a tie the requester not served last wins.
  always_comb begin
    pick = GNT_SPI;
    if (!spi_pend_q) pick = GNT_HOST;
    else if (host_req && (last_q == GNT_SPI)) pick = GNT_HOST;
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    last_d        = last_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    spi_pend_d    = spi_pend_q;
    spi_cmd_d     = spi_cmd_q;
    spi_byte_d    = spi_byte_q;
    dout_d        = dout_q;
    tx_valid_d    = tx_valid_q;
    host_gnt_d    = 1'b0;
    host_rdata_d  = host_rdata_q;
    host_rvalid_d = 1'b0;
    overrun_d     = overrun_q;

    if (rx_valid) tx_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (spi_pend_q || host_req) begin
          gnt_d      = pick;
          last_d     = pick;
          host_gnt_d = (pick == GNT_HOST);
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (spi_acc) begin
          spi_pend_d = 1'b0;
          if (acc_write) wr_addr_d = wr_addr_q + ADDR_SIZE'(1);
          else           rd_addr_d = rd_addr_q + ADDR_SIZE'(1);
        end
        state_d = acc_write ? IDLE : RDATA;
      end
      RDATA: begin
        if (gnt_q == GNT_SPI) begin
          dout_d     = ram_q;
          tx_valid_d = 1'b1;
        end else begin
          host_rdata_d  = ram_q;
          host_rvalid_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new command takes priority over the pointer bump / slot clear of a completing access.
    if (rx_valid) begin
      if (spi_pend_q && !spi_acc) overrun_d = 1'b1;
      case (din[9:8])
        CMD_WR_ADDR: wr_addr_d = din[ADDR_SIZE-1:0];
        CMD_RD_ADDR: rd_addr_d = din[ADDR_SIZE-1:0];
        default: begin
          spi_pend_d = 1'b1;
          spi_cmd_d  = din[9:8];
          spi_byte_d = din[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gnt_q         <= GNT_SPI;
      last_q        <= GNT_HOST;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      spi_pend_q    <= 1'b0;
      spi_cmd_q     <= CMD_WR_ADDR;
      spi_byte_q    <= 8'h00;
      dout_q        <= 8'h00;
      tx_valid_q    <= 1'b0;
      host_gnt_q    <= 1'b0;
      host_rdata_q  <= 8'h00;
      host_rvalid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      last_q        <= last_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      spi_pend_q    <= spi_pend_d;
      spi_cmd_q     <= spi_cmd_d;
      spi_byte_q    <= spi_byte_d;
      dout_q        <= dout_d;
      tx_valid_q    <= tx_valid_d;
      host_gnt_q    <= host_gnt_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign dout        = dout_q;
  assign tx_valid    = tx_valid_q;
  assign host_gnt    = host_gnt_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign overrun     = overrun_q;

endmodule
